conv_fitofp_pipe: RTL and testbench

- Multi-lane, pipelined converter from two's-complement fixed-point to a parametrised IEEE-style float (BF16 by default).
- Applies an MX shared-scale exponent offset and rounds RNE.
- Overflow goes to inf; underflow flushes to signed zero.
- Sits between the fixed-point dot-product accumulators and float consumers on a valid/ready stream.

---
 rtl/conv_fitofp_pipe_pkg.sv | 42 ++++
 rtl/conv_fitofp_pipe_if.sv | 28 ++
 rtl/conv_fitofp_pipe_fitofp_lane.sv | 115 +++++++++++
 rtl/conv_fitofp_pipe.sv | 74 +++++++
 tb/tb_conv_fitofp_pipe.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_fitofp_pipe_pkg.sv
// Shared types and helpers for the fixed-point to float converter.
// Holds the named float formats, the exponent bias and the internal exponent width.
package conv_fitofp_pipe_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef struct packed {
    logic                  sgn;
    logic [BF16_EXP_W-1:0] exp;
    logic [BF16_MAN_W-1:0] man;
  } bf16_t;

  typedef struct packed {
    logic                  sgn;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_t;

  typedef struct packed {
    logic                  sgn;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Signed width that holds the biased exponent for every input, scale and round carry.
  function automatic int exp_calc_w(input int bit_w, input int frac_w,
                                    input int exp_w, input int scale_w);
    int mag;
    mag = bit_w + frac_w + (1 << exp_w) + (1 << (scale_w - 1)) + 2;
    return $clog2(mag) + 2;
  endfunction

endpackage

// File: rtl/conv_fitofp_pipe_if.sv
// Valid/ready stream bundle for conv_fitofp_pipe: fixed-point beat in, float beat out.
interface conv_fitofp_pipe_if #(
  parameter int LANES   = 4,
  parameter int BIT_W   = 16,
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 7,
  parameter int SCALE_W = 8
);
  localparam int FP_W = 1 + EXP_W + MAN_W;

  logic                      i_valid;
  logic                      o_ready;
  logic [LANES*BIT_W-1:0]    i_data;
  logic signed [SCALE_W-1:0] i_scale;
  logic                      o_valid;
  logic                      i_ready;
  logic [LANES*FP_W-1:0]     o_data;

  modport slave (
    input  i_valid, i_data, i_scale, i_ready,
    output o_ready, o_valid, o_data
  );

  modport master (
    output i_valid, i_data, i_scale, i_ready,
    input  o_ready, o_valid, o_data
  );
endinterface

// File: rtl/conv_fitofp_pipe_fitofp_lane.sv
// One conversion lane: S1 sign/magnitude, S2 normalise, S3 round and pack.
// CONV_FITOFP_SAT_EN selects saturation to max finite instead of inf on overflow.
module fitofp_lane
  import conv_fitofp_pipe_pkg::*;
#(
  parameter int BIT_W   = 16,
  parameter int FRAC_W  = 0,
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 7,
  parameter int SCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld1,
  input  logic                      ld2,
  input  logic                      ld3,
  input  logic [BIT_W-1:0]          data,
  input  logic signed [SCALE_W-1:0] scale,
  output logic [EXP_W+MAN_W:0]      result
);
  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float_t;

  localparam int LZ_W  = $clog2(BIT_W + 1);
  localparam int EW    = exp_calc_w(BIT_W, FRAC_W, EXP_W, SCALE_W);
  localparam int EXT_W = BIT_W + MAN_W;
  localparam logic signed [EW-1:0] E_OFS  = EW'(BIT_W - 1 - FRAC_W + fp_bias(EXP_W));
  localparam logic signed [EW-1:0] E_TOP  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  logic             s1_sgn;
  logic [BIT_W-1:0] s1_mag;

  // Negating the most-negative input wraps to 2^(BIT_W-1), which is the correct unsigned magnitude.
  always_ff @(posedge clk) begin
    if (ld1) begin
      s1_sgn <= data[BIT_W-1];
      s1_mag <= data[BIT_W-1] ? -data : data;
    end
  end

  logic [LZ_W-1:0]  lz;
  logic [BIT_W-1:0] aligned;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lz = LZ_W'(BIT_W);
    for (int i = 0; i < BIT_W; i++) begin
      if (s1_mag[i]) lz = LZ_W'(BIT_W - 1 - i);
    end
    aligned = s1_mag << lz;
  end

  logic             s2_sgn;
  logic             s2_zero;
  logic [LZ_W-1:0]  s2_lz;
  logic [BIT_W-1:0] s2_aligned;

  always_ff @(posedge clk) begin
    if (ld2) begin
      s2_sgn     <= s1_sgn;
      s2_zero    <= (s1_mag == '0);
      s2_lz      <= lz;
      s2_aligned <= aligned;
    end
  end

  logic [EXT_W-1:0]      ext;
  logic [MAN_W-1:0]      man;
  logic [MAN_W-1:0]      man_rnd;
  logic                  rnd_r;
  logic                  rnd_s;
  logic                  carry;
  logic signed [EW-1:0]  e_biased;
  float_t                pack;

  // Zero padding below the fraction makes R and S vanish when the input is narrower than the mantissa.
  always_comb begin
    ext   = {s2_aligned[BIT_W-2:0], {(MAN_W+1){1'b0}}};
    man   = ext[EXT_W-1 -: MAN_W];
    rnd_r = ext[BIT_W-1];
    rnd_s = |ext[BIT_W-2:0];
    {carry, man_rnd} = {1'b0, man} + (MAN_W+1)'(rnd_r & (man[0] | rnd_s));
    e_biased = E_OFS - $signed(EW'(s2_lz)) + EW'(scale) + $signed(EW'(carry));

    pack = '0;
    if (s2_zero) begin
      pack = '0;
    end else if (e_biased >= E_TOP) begin
      pack.sgn = s2_sgn;
`ifdef CONV_FITOFP_SAT_EN
      pack.exp = EXP_W'((1 << EXP_W) - 2);
      pack.man = '1;
`else
      pack.exp = '1;
      pack.man = '0;
`endif
    end else if (e_biased <= E_ZERO) begin
      pack.sgn = s2_sgn;
    end else begin
      pack.sgn = s2_sgn;
      pack.exp = e_biased[EXP_W-1:0];
      pack.man = man_rnd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) result <= '0;
    else if (ld3) result <= pack;
  end

endmodule

// File: rtl/conv_fitofp_pipe.sv
// LANES-wide, 3-stage fixed-point to float converter with shared scale and valid/ready flow.
// CONV_FITOFP_SAT_EN selects saturation to max finite instead of inf on overflow.
module conv_fitofp_pipe
  import conv_fitofp_pipe_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int BIT_W   = 16,
  parameter int FRAC_W  = 0,
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 7,
  parameter int SCALE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  conv_fitofp_pipe_if.slave bus
);
  localparam int FP_W = 1 + EXP_W + MAN_W;

  logic v1, v2, v3;
  logic adv1, adv2, adv3;
  logic ld1, ld2, ld3;
  logic signed [SCALE_W-1:0] scale1, scale2;

  // A stage may advance when empty or when the one after it advances, so bubbles collapse.
  always_comb begin
    adv3 = !v3 || bus.i_ready;
    adv2 = !v2 || adv3;
    adv1 = !v1 || adv2;
    ld1  = adv1 && bus.i_valid;
    ld2  = adv2 && v1;
    ld3  = adv3 && v2;
  end

  assign bus.o_ready = adv1;
  assign bus.o_valid = v3;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (adv1) v1 <= bus.i_valid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
    end
  end

  // NOTE: datapath registers carry no reset; the valid flags alone decide what is meaningful.
  always_ff @(posedge i_clk) begin
    if (ld1) scale1 <= bus.i_scale;
    if (ld2) scale2 <= scale1;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fitofp_lane #(
      .BIT_W  (BIT_W),
      .FRAC_W (FRAC_W),
      .EXP_W  (EXP_W),
      .MAN_W  (MAN_W),
      .SCALE_W(SCALE_W)
    ) u_lane (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .ld1   (ld1),
      .ld2   (ld2),
      .ld3   (ld3),
      .data  (bus.i_data[k*BIT_W +: BIT_W]),
      .scale (scale2),
      .result(bus.o_data[k*FP_W +: FP_W])
    );
  end

endmodule

// File: tb/tb_conv_fitofp_pipe.sv
// Directed bench for conv_fitofp_pipe in the default BF16, 4-lane, 16-bit configuration.
`timescale 1ns/1ps
module tb_conv_fitofp_pipe;
  localparam int LANES   = 4;
  localparam int BIT_W   = 16;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 7;
  localparam int SCALE_W = 8;
  localparam int DW      = 64;
  localparam int OW      = 64;

`ifdef CONV_FITOFP_SAT_EN
  localparam logic [15:0] POS_OVF = 16'h7F7F;
  localparam logic [15:0] NEG_OVF = 16'hFF7F;
`else
  localparam logic [15:0] POS_OVF = 16'h7F80;
  localparam logic [15:0] NEG_OVF = 16'hFF80;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_fitofp_pipe_if #(
    .LANES(LANES), .BIT_W(BIT_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .SCALE_W(SCALE_W)
  ) bus ();

  conv_fitofp_pipe #(
    .LANES(LANES), .BIT_W(BIT_W), .FRAC_W(0), .EXP_W(EXP_W), .MAN_W(MAN_W), .SCALE_W(SCALE_W)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    string                     name;
    logic [DW-1:0]             data;
    logic signed [SCALE_W-1:0] scale;
    logic [OW-1:0]             expect_q;
  } vec_t;

  vec_t vecs[7];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Small stream model: lane0 = 2^i, lane1 = -2^i, lanes 2/3 zero.
  function automatic logic [DW-1:0] stream_data(input int i);
    logic [15:0] p;
    p = 16'(1 << i);
    return {16'h0000, 16'h0000, -p, p};
  endfunction

  function automatic logic [OW-1:0] stream_exp(input int i);
    logic [15:0] f;
    f = 16'((127 + i) << 7);
    return {16'h0000, 16'h0000, 16'h8000 | f, f};
  endfunction

  // Presents one beat, then counts cycles until o_valid (acceptance cycle counts as 1).
  task automatic send_one(input string name, input logic [DW-1:0] d,
                          input logic signed [SCALE_W-1:0] s, input logic [OW-1:0] req);
    int lat;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_scale = s;
    step();
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 10) begin
      step();
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_data"}, bus.o_data, req);
    step();
  endtask

  initial begin
    int nin, nout, stalled;
    logic [OW-1:0] held;
    int in_cyc[6];
    int out_cyc[6];

    vecs[0] = '{"basic",    64'h8000_0000_FFFF_0001, 8'sd0,    64'hC700_0000_BF80_3F80};
    vecs[1] = '{"rne_tie",  64'hFEFF_7FFF_0103_0101, 8'sd0,    64'hC380_4700_4382_4380};
    vecs[2] = '{"ovf",      64'h0000_0001_8001_7FFF, 8'sd127,  {16'h0000, 16'h7F00, NEG_OVF, POS_OVF}};
    vecs[3] = '{"uflow",    64'h0000_0002_FFFF_0001, -8'sd127, 64'h0000_0080_8000_0000};
    vecs[4] = '{"min_norm", 64'h0064_0003_FFFF_0001, -8'sd126, 64'h03C8_0140_8080_0080};
    vecs[5] = '{"scale5",   64'h0007_4000_FFFB_0064, 8'sd5,    64'h4360_4900_C320_4548};
    vecs[6] = '{"sticky",   64'h03E8_FE7D_0183_0203, 8'sd0,    64'h447A_C3C2_43C2_4401};

    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_scale = '0;
    bus.i_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_o_valid", 64'(bus.o_valid), 64'd0);
    check("reset_o_data", bus.o_data, 64'd0);
    rst_n = 1'b1;
    step();
    check("reset_o_ready", 64'(bus.o_ready), 64'd1);

    for (int v = 0; v < 7; v++) begin
      send_one(vecs[v].name, vecs[v].data, vecs[v].scale, vecs[v].expect_q);
    end

    // Backpressure: ten back-to-back beats, downstream stalls for cycles 4..8.
    nin = 0;
    nout = 0;
    stalled = 0;
    held = '0;
    for (int cyc = 0; cyc < 60 && nout < 10; cyc++) begin
      bus.i_ready = !(cyc >= 4 && cyc <= 8);
      bus.i_valid = (nin < 10);
      bus.i_data  = stream_data(nin);
      bus.i_scale = '0;
      @(negedge clk);
      if (bus.o_valid && !bus.i_ready) begin
        if (stalled != 0) check("bp_hold_stable", bus.o_data, held);
        held = bus.o_data;
        stalled = 1;
      end else begin
        stalled = 0;
      end
      if (cyc == 8) check("bp_o_ready_full", 64'(bus.o_ready), 64'd0);
      if (bus.o_valid && bus.i_ready) begin
        check($sformatf("bp_beat%0d", nout), bus.o_data, stream_exp(nout));
        nout++;
      end
      if (bus.i_valid && bus.o_ready) nin++;
      step();
    end
    check("bp_out_count", 64'(nout), 64'd10);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (4) step();
    check("bp_no_extra", 64'(bus.o_valid), 64'd0);

    // i_valid every other cycle: each beat must come out exactly 3 cycles after acceptance.
    nin = 0;
    nout = 0;
    for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
      bus.i_valid = (cyc % 2 == 0) && (nin < 6);
      bus.i_data  = stream_data(nin + 3);
      @(negedge clk);
      if (bus.o_valid && bus.i_ready) begin
        out_cyc[nout] = cyc;
        check($sformatf("tog_beat%0d", nout), bus.o_data, stream_exp(nout + 3));
        nout++;
      end
      if (bus.i_valid && bus.o_ready) begin
        in_cyc[nin] = cyc;
        nin++;
      end
      step();
    end
    check("tog_out_count", 64'(nout), 64'd6);
    for (int i = 0; i < nout; i++) begin
      check($sformatf("tog_lat%0d", i), 64'(out_cyc[i] - in_cyc[i]), 64'd3);
    end
    bus.i_valid = 1'b0;
    repeat (2) step();

    // Reset with the pipeline full and stalled.
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = vecs[i].data;
      bus.i_scale = vecs[i].scale;
      step();
    end
    bus.i_valid = 1'b0;
    check("rst_pre_o_valid", 64'(bus.o_valid), 64'd1);
    rst_n = 1'b0;
    step();
    check("rst_o_valid", 64'(bus.o_valid), 64'd0);
    check("rst_o_data", bus.o_data, 64'd0);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    step();
    check("rst_no_stale", 64'(bus.o_valid), 64'd0);
    send_one("post_rst", vecs[0].data, vecs[0].scale, vecs[0].expect_q);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
